arm_instr_encoder: RTL

//  Encoder counterpart of the control decoder: turns field-level instruction requests into 32-bit
//  ARM words for the decoded subset (DP ADD/SUB/AND/ORR, LDR/STR, B).

---
 rtl/arm_instr_encoder.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/arm_instr_encoder.sv
// Turns field-level instruction requests into 32-bit ARM words and streams them into
// instruction memory, padding the unused tail with NOPs.
//
// state | meaning
// IDLE  | waiting for start after reset
// LOAD  | accepting requests, one word written per legal beat
// PAD   | writing NOPs until the memory is full
// DONE  | program complete; count/err/full held until next start
module arm_instr_encoder #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_kind,
    input  logic [3:0]        in_cond,
    input  logic              in_imm_sel,
    input  logic [1:0]        in_alu_op,
    input  logic              in_s,
    input  logic              in_load,
    input  logic [3:0]        in_rn,
    input  logic [3:0]        in_rd,
    input  logic [3:0]        in_rm,
    input  logic [23:0]       in_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              done,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, LOAD, PAD, DONE} state_t;

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [31:0]     NOP   = 32'hE280_0000;

    state_t              state_q, state_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                err_q, err_d;
    logic                accept, illegal;
    logic [3:0]          cmd;
    logic [31:0]         enc_word;

    assign full     = (count_q == DEPTH);
    assign in_ready = (state_q == LOAD) && !full;
    assign accept   = in_valid && in_ready;
    assign illegal  = (in_kind == 2'd3) || ((in_kind == 2'd1) && !in_imm_sel);

    always_comb begin
        case (in_alu_op)
            2'b00:   cmd = 4'b0100;
            2'b01:   cmd = 4'b0010;
            2'b10:   cmd = 4'b0000;
            default: cmd = 4'b1100;
        endcase
    end

    always_comb begin
        case (in_kind)
            2'd0:    enc_word = {in_cond, 2'b00, in_imm_sel, cmd, in_s, in_rn, in_rd,
                                 in_imm_sel ? in_imm[11:0] : {8'h00, in_rm}};
            2'd1:    enc_word = {in_cond, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, in_load,
                                 in_rn, in_rd, in_imm[11:0]};
            default: enc_word = {in_cond, 4'b1010, in_imm};
        endcase
    end

    always_comb begin
        state_d     = state_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        count_d     = count_q;
        err_d       = err_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = LOAD;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            LOAD: begin
                if (accept) begin
                    if (illegal) begin
                        err_d = 1'b1;
                    end else begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = count_q[ADDR_W-1:0];
                        mem_wdata_d = enc_word;
                        count_d     = count_q + ONE;
                    end
                end
                // Filling the last slot wins over finish: nothing is left to pad.
                if (count_d == DEPTH)
                    state_d = DONE;
                else if (finish)
                    state_d = PAD;
            end
            PAD: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = count_q[ADDR_W-1:0];
                mem_wdata_d = NOP;
                count_d     = count_q + ONE;
                if (count_d == DEPTH)
                    state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            count_q     <= count_d;
            err_q       <= err_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign count     = count_q;
    assign err       = err_q;
    assign done      = (state_q == DONE);
endmodule
